clk_en_gen: RTL and testbench

Parametrised clock-enable and reset sequencer that sits directly behind the Gowin rPLL wrapper. It consumes the PLL's `LOCK` output and holds the system in reset until lock has been stable for a configurable time. It then generates `NUM_CH` independent one-cycle clock-enable strobes, each with its own divisor that software can reprogram at runtime. This replaces per-peripheral fixed PLL outputs: one PLL clock plus enables drives the SoC.

---
 rtl/clk_en_gen.sv | 162 ++++++++++++++++
 tb/tb_clk_en_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clk_en_gen
//  Purpose  : Reset sequencer and clock-enable generator that sits behind the
//             PLL. It holds the system in reset until the synchronised PLL
//             lock has been stable for LOCK_STABLE cycles. While running, it
//             produces NUM_CH one-cycle enable strobes, and the divisor of
//             each strobe can be reprogrammed at runtime.
//  Options  : CLK_EN_GEN_LOCK_MON_EN - when defined, the saturating lock-loss
//             counter is built. When undefined, lock_loss_cnt is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_STABLE = 1024,
  parameter int DEFAULT_DIV = 27,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_val,
  output logic [NUM_CH-1:0] ce,
  output logic              sys_rst_n,
  output logic              ready,
  output logic [7:0]        lock_loss_cnt
);

  // Stable counter only has to reach LOCK_STABLE-1.
  localparam int ST_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [ST_W-1:0]  STABLE_LAST = ST_W'(LOCK_STABLE - 1);
  localparam logic [DIV_W-1:0] DIV_RESET   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t          r_state;
  logic [ST_W-1:0] r_stable_cnt;
  logic [1:0]      r_sync;
  logic            lock_s;
  logic            w_in_run;
  logic            w_run_hold;

  // Bring the asynchronous PLL lock into the clk domain with two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], pll_lock};
    end
  end

  assign lock_s = r_sync[1];

  // w_run_hold is true when the FSM is in RUN and stays in RUN after this
  // edge. Channel counters advance only in that case, so they read 0 in
  // every other state, including the cycle right after a lock loss.
  assign w_in_run   = (r_state == RUN);
  assign w_run_hold = w_in_run && lock_s;

  // Lock qualification FSM. sys_rst_n and ready are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_LOCK;
      r_stable_cnt <= '0;
      sys_rst_n    <= 1'b0;
      ready        <= 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          r_stable_cnt <= '0;
          if (lock_s) begin
            r_state <= STABLE;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            r_state      <= WAIT_LOCK;
            r_stable_cnt <= '0;
          end else if (r_stable_cnt == STABLE_LAST) begin
            r_state      <= RUN;
            r_stable_cnt <= '0;
            sys_rst_n    <= 1'b1;
            ready        <= 1'b1;
          end else begin
            r_stable_cnt <= r_stable_cnt + ST_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            r_state   <= WAIT_LOCK;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
          end
        end
        default: begin
          r_state      <= WAIT_LOCK;
          r_stable_cnt <= '0;
          sys_rst_n    <= 1'b0;
          ready        <= 1'b0;
        end
      endcase
    end
  end

  // One divisor register, one counter and one strobe per channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             w_hit;
    logic             w_last;

    // An out-of-range select matches no channel, so that write is dropped.
    assign w_hit  = div_wr && (div_sel == SEL_W'(i));
    assign w_last = (r_div != '0) && (r_cnt == (r_div - DIV_ONE));

    // A write restarts the phase of the channel. Otherwise the channel
    // counts 0..N-1 while running and is held at 0 when not running.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_div <= DIV_RESET;
        r_cnt <= '0;
      end else if (w_hit) begin
        r_div <= div_val;
        r_cnt <= '0;
      end else if (w_run_hold && (r_div != '0)) begin
        r_cnt <= w_last ? '0 : (r_cnt + DIV_ONE);
      end else begin
        r_cnt <= '0;
      end
    end

    // Driven only from registers, so no input-to-output combinational path.
    assign ce[i] = w_in_run && w_last;
  end

`ifdef CLK_EN_GEN_LOCK_MON_EN
  logic [7:0] r_loss_cnt;

  // Count each RUN -> WAIT_LOCK transition and saturate at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= 8'd0;
    end else if (w_in_run && !lock_s && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_en_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_en_gen
//  Purpose  : Directed self-checking bench for clk_en_gen. Each scenario task
//             drives stimulus and compares the DUT outputs against values
//             worked out by hand.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_en_gen;

  localparam int NUM_CH = 5;
  localparam int LS     = 16;
`ifdef CLK_EN_GEN_LOCK_MON_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        pll_lock;
  logic        div_wr;
  logic [2:0]  div_sel;
  logic [15:0] div_val;
  logic [4:0]  ce;
  logic        sys_rst_n;
  logic        ready;
  logic [7:0]  lock_loss_cnt;

  int n_tests;
  int n_fail;
  int edge_n;
  int run_edge;

  clk_en_gen #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (16),
    .LOCK_STABLE (LS),
    .DEFAULT_DIV (27)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .div_wr        (div_wr),
    .div_sel       (div_sel),
    .div_val       (div_val),
    .ce            (ce),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges. Outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  // Drive-only helper: reset with lock low, released just after an edge.
  // The next edge after the release is numbered edge 1.
  task automatic do_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    div_wr   = 1'b0;
    div_sel  = 3'd0;
    div_val  = 16'd0;
    tick(3);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    tick(2);
    n_tests++;
    if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); end
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_tests++;
    if (ce !== 5'd0) begin n_fail++; $display("FAIL reset_ce: got %h want 0", ce); end
    n_tests++;
    if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss: got %0d want 0", lock_loss_cnt); end
    rst_n = 1'b1;
    tick(6);
    n_tests++;
    if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL nolock_sys_rst_n: got %b want 0", sys_rst_n); end
  endtask

  task automatic test_powerup();
    logic [4:0] exp;
    do_reset();
    pll_lock = 1'b1;
    tick(18);
    n_tests++;
    if (sys_rst_n !== 1'b0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL pwr_early: sys_rst_n=%b ready=%b want 0 0 at edge 18", sys_rst_n, ready);
    end
    tick(1);
    run_edge = 19;
    n_tests++;
    if (sys_rst_n !== 1'b1 || ready !== 1'b1) begin
      n_fail++; $display("FAIL pwr_release: sys_rst_n=%b ready=%b want 1 1 at edge 19", sys_rst_n, ready);
    end
    // Default divisor 27: the first strobe is at edge 45, then every 27.
    for (int e = 19; e <= 19 + 60; e++) begin
      if (e > 19) tick(1);
      exp = (((edge_n - 19) % 27) == 26) ? 5'h1F : 5'h00;
      n_tests++;
      if (ce !== exp) begin n_fail++; $display("FAIL pwr_ce edge %0d: got %h want %h", edge_n, ce, exp); end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    pll_lock = 1'b1;
    tick(12);
    pll_lock = 1'b0;          // low for edge 13 only
    tick(1);
    pll_lock = 1'b1;
    tick(6);                  // edge 19: an unglitched run would be released here
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL glitch_edge19: ready=%b want 0", ready); end
    tick(12);                 // edge 31
    n_tests++;
    if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL glitch_edge31: sys_rst_n=%b want 0", sys_rst_n); end
    tick(1);                  // edge 32 = 13 + 3 + 16
    run_edge = 32;
    n_tests++;
    if (sys_rst_n !== 1'b1 || ready !== 1'b1) begin
      n_fail++; $display("FAIL glitch_release: sys_rst_n=%b ready=%b want 1 1", sys_rst_n, ready);
    end
    n_tests++;
    if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL glitch_loss: got %0d want 0", lock_loss_cnt); end
  endtask

  task automatic test_divisors();
    int         w3;
    logic [4:0] exp;
    tick(3);
    div_wr = 1'b1; div_sel = 3'd1; div_val = 16'd1;
    tick(1);
    div_sel = 3'd2; div_val = 16'd0;
    tick(1);
    div_sel = 3'd3; div_val = 16'd5;
    tick(1);
    w3 = edge_n;
    div_sel = 3'd5; div_val = 16'd9;   // out of range: ignored
    tick(1);
    div_sel = 3'd7; div_val = 16'd2;   // out of range: ignored
    tick(1);
    div_wr = 1'b0;
    for (int k = 0; k < 30; k++) begin
      exp[0] = (((edge_n - run_edge) % 27) == 26);
      exp[4] = exp[0];
      exp[1] = 1'b1;
      exp[2] = 1'b0;
      exp[3] = (((edge_n - w3) % 5) == 4);
      n_tests++;
      if (ce !== exp) begin n_fail++; $display("FAIL div_ce edge %0d: got %h want %h", edge_n, ce, exp); end
      tick(1);
    end
  endtask

  task automatic test_lock_loss();
    logic [7:0] exp_cnt;
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      tick(2);
      n_tests++;
      if (sys_rst_n !== 1'b1) begin n_fail++; $display("FAIL loss_k1 iter %0d: sys_rst_n=%b want 1", i, sys_rst_n); end
      tick(1);
      n_tests++;
      if (sys_rst_n !== 1'b0 || ready !== 1'b0 || ce !== 5'd0) begin
        n_fail++; $display("FAIL loss_k2 iter %0d: sys_rst_n=%b ready=%b ce=%h want 0 0 0", i, sys_rst_n, ready, ce);
      end
      exp_cnt = LOSS_EN ? ((i + 1 > 255) ? 8'd255 : 8'(i + 1)) : 8'd0;
      n_tests++;
      if (lock_loss_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL loss_cnt iter %0d: got %0d want %0d", i, lock_loss_cnt, exp_cnt);
      end
      pll_lock = 1'b1;
      tick(18);
      n_tests++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL loss_relock_early iter %0d: ready=%b want 0", i, ready); end
      tick(1);
      n_tests++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_relock iter %0d: ready=%b want 1", i, ready); end
    end
  endtask

  task automatic test_async_reset();
    div_wr = 1'b1; div_sel = 3'd0; div_val = 16'd3;
    tick(1);
    div_wr = 1'b0;
    tick(2);
    n_tests++;
    if (ce[0] !== 1'b1) begin n_fail++; $display("FAIL ar_div3_hit: ce0=%b want 1", ce[0]); end
    tick(1);
    n_tests++;
    if (ce[0] !== 1'b0) begin n_fail++; $display("FAIL ar_div3_gap: ce0=%b want 0", ce[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (sys_rst_n !== 1'b0 || ready !== 1'b0 || ce !== 5'd0 || lock_loss_cnt !== 8'd0) begin
      n_fail++; $display("FAIL ar_immediate: sys_rst_n=%b ready=%b ce=%h loss=%0d want all 0",
                         sys_rst_n, ready, ce, lock_loss_cnt);
    end
    tick(1);
    rst_n  = 1'b1;
    edge_n = 0;
    for (int e = 1; e <= 46; e++) begin
      tick(1);
      if (edge_n == 18 || edge_n == 19) begin
        n_tests++;
        if (sys_rst_n !== (edge_n == 19)) begin
          n_fail++; $display("FAIL ar_release edge %0d: sys_rst_n=%b", edge_n, sys_rst_n);
        end
      end
      n_tests++;
      if (ce[0] !== (edge_n == 45)) begin
        n_fail++; $display("FAIL ar_default_div edge %0d: ce0=%b want %b", edge_n, ce[0], (edge_n == 45));
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    edge_n   = 0;
    run_edge = 0;
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    div_wr   = 1'b0;
    div_sel  = 3'd0;
    div_val  = 16'd0;
    test_reset();
    test_powerup();
    test_glitch();
    test_divisors();
    test_lock_loss();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
